cache_nway_ctrl: RTL and testbench

- Parametrised set-associative cache controller; successor to the fixed L1/L2 configuration.
- Ways, sets, block size and write policy are all generic; one instance serves as L1 or L2.
- Sits between processor (word-wide valid/ready request, one-cycle response) and next level/memory (block-wide request/ack).
- Adds true-LRU replacement, dirty-victim write-back, write-allocate, and hit/miss counters.

---
 rtl/cache_nway_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_cache_nway_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_ctrl.sv
// Parametrised set-associative cache controller: true-LRU replacement, write-allocate,
// write-back or write-through policy, block-wide memory side and saturating hit/miss counters.
module cache_nway_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WAYS         = 4,
    parameter int NUM_SETS     = 4,
    parameter int BLOCK_WORDS  = 4,
    parameter int WRITE_POLICY = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cpu_req_valid,
    output logic                              cpu_req_ready,
    input  logic                              cpu_req_we,
    input  logic [ADDR_WIDTH-1:0]             cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]             cpu_req_wdata,
    output logic                              cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]             cpu_resp_rdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH*BLOCK_WORDS-1:0] mem_wdata,
    input  logic [DATA_WIDTH*BLOCK_WORDS-1:0] mem_rdata,
    input  logic                              mem_ack,
    output logic [31:0]                       hit_count,
    output logic [31:0]                       miss_count
);
    localparam int WO_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFF_W = WO_W + 2;
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W = DATA_WIDTH * BLOCK_WORDS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        WTHRU     = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [BLK_W-1:0]        data_r  [WAYS][NUM_SETS];
    logic [TAG_W-1:0]        tag_r   [WAYS][NUM_SETS];
    logic [WAYS-1:0]         valid_r [NUM_SETS];
    logic [WAYS-1:0]         dirty_r [NUM_SETS];
    logic [WAY_W-1:0]        age_r   [NUM_SETS][WAYS];

    logic                    req_we_r;
    logic [ADDR_WIDTH-1:2]   req_addr_r;
    logic [DATA_WIDTH-1:0]   req_wdata_r;
    logic [WAY_W-1:0]        victim_r;
    logic                    refill_r;

    logic [IDX_W-1:0]        idx_s;
    logic [WO_W-1:0]         wo_s;
    logic [TAG_W-1:0]        tag_s;
    logic [ADDR_WIDTH-1:0]   blk_addr_s;
    logic                    hit_s;
    logic                    victim_found_s;
    logic [WAY_W-1:0]        hit_way_s;
    logic [WAY_W-1:0]        victim_s;
    logic [BLK_W-1:0]        hit_block_s;
    logic [BLK_W-1:0]        upd_block_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic                    resp_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic [BLK_W-1:0]        mem_wdata_s;
    logic                    unused_s;

    // Byte offset within a word is irrelevant for word-wide accesses
    assign unused_s   = &{1'b0, cpu_req_addr[1:0]};
    assign idx_s      = req_addr_r[OFF_W +: IDX_W];
    assign wo_s       = req_addr_r[2 +: WO_W];
    assign tag_s      = req_addr_r[ADDR_WIDTH-1 -: TAG_W];
    assign blk_addr_s = {req_addr_r[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    // Tag match, victim choice and word access for the set of the latched request
    always_comb begin
        hit_s          = 1'b0;
        hit_way_s      = {WAY_W{1'b0}};
        victim_found_s = 1'b0;
        victim_s       = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_s && valid_r[idx_s][w] && (tag_r[w][idx_s] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s = hit_s;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found_s && !valid_r[idx_s][w]) begin
                victim_found_s = 1'b1;
                victim_s       = WAY_W'(w);
            end else begin
                victim_found_s = victim_found_s;
            end
        end
        // Ages are a permutation, so the oldest way carries age WAYS-1
        if (!victim_found_s) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_r[idx_s][w] == WAY_W'(WAYS - 1)) begin
                    victim_s = WAY_W'(w);
                end else begin
                    victim_s = victim_s;
                end
            end
        end else begin
            victim_s = victim_s;
        end
        hit_block_s = data_r[hit_way_s][idx_s];
        upd_block_s = hit_block_s;
        upd_block_s[wo_s*DATA_WIDTH +: DATA_WIDTH] = req_wdata_r;
        rd_word_s   = hit_block_s[wo_s*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next state, response and the memory address/block loaded when a memory phase starts
    always_comb begin
        state_s     = state_r;
        resp_s      = 1'b0;
        rdata_s     = {DATA_WIDTH{1'b0}};
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        case (state_r)
            IDLE: begin
                if (cpu_req_valid && cpu_req_ready) begin
                    state_s = COMPARE;
                end else begin
                    state_s = IDLE;
                end
            end
            COMPARE: begin
                if (hit_s) begin
                    if (req_we_r && (WRITE_POLICY == 0)) begin
                        state_s     = WTHRU;
                        mem_addr_s  = blk_addr_s;
                        mem_wdata_s = upd_block_s;
                    end else begin
                        state_s = IDLE;
                        resp_s  = 1'b1;
                        if (!req_we_r) begin
                            rdata_s = rd_word_s;
                        end else begin
                            rdata_s = {DATA_WIDTH{1'b0}};
                        end
                    end
                end else if (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) begin
                    state_s     = WRITEBACK;
                    mem_addr_s  = {tag_r[victim_s][idx_s], idx_s, {OFF_W{1'b0}}};
                    mem_wdata_s = data_r[victim_s][idx_s];
                end else begin
                    state_s    = ALLOCATE;
                    mem_addr_s = blk_addr_s;
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    state_s    = ALLOCATE;
                    mem_addr_s = blk_addr_s;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (mem_ack) begin
                    state_s = COMPARE;
                end else begin
                    state_s = ALLOCATE;
                end
            end
            WTHRU: begin
                if (mem_ack) begin
                    state_s = IDLE;
                    resp_s  = 1'b1;
                end else begin
                    state_s = WTHRU;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Controller state, latched request, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            req_we_r       <= 1'b0;
            req_addr_r     <= {(ADDR_WIDTH-2){1'b0}};
            req_wdata_r    <= {DATA_WIDTH{1'b0}};
            victim_r       <= {WAY_W{1'b0}};
            cpu_req_ready  <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= {DATA_WIDTH{1'b0}};
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= {ADDR_WIDTH{1'b0}};
            mem_wdata      <= {BLK_W{1'b0}};
            hit_count      <= 32'd0;
            miss_count     <= 32'd0;
        end else begin
            state_r        <= state_s;
            cpu_req_ready  <= (state_s == IDLE);
            cpu_resp_valid <= resp_s;
            cpu_resp_rdata <= rdata_s;
            mem_req        <= (state_s == WRITEBACK) || (state_s == ALLOCATE) || (state_s == WTHRU);
            mem_we         <= (state_s == WRITEBACK) || (state_s == WTHRU);
            mem_addr       <= mem_addr_s;
            mem_wdata      <= mem_wdata_s;
            if ((state_r == IDLE) && cpu_req_valid && cpu_req_ready) begin
                req_we_r    <= cpu_req_we;
                req_addr_r  <= cpu_req_addr[ADDR_WIDTH-1:2];
                req_wdata_r <= cpu_req_wdata;
            end else begin
                req_we_r    <= req_we_r;
                req_addr_r  <= req_addr_r;
                req_wdata_r <= req_wdata_r;
            end
            // The re-compare after a fill is not a new hit
            if ((state_r == COMPARE) && hit_s && !refill_r && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                hit_count <= hit_count;
            end
            if ((state_r == COMPARE) && !hit_s) begin
                victim_r <= victim_s;
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end else begin
                    miss_count <= miss_count;
                end
            end else begin
                victim_r   <= victim_r;
                miss_count <= miss_count;
            end
        end
    end

    // Tag, data, valid, dirty and LRU age storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refill_r <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= {WAYS{1'b0}};
                dirty_r[s] <= {WAYS{1'b0}};
                for (int w = 0; w < WAYS; w++) begin
                    age_r[s][w]  <= WAY_W'(w);
                    data_r[w][s] <= {BLK_W{1'b0}};
                    tag_r[w][s]  <= {TAG_W{1'b0}};
                end
            end
        end else if ((state_r == COMPARE) && hit_s) begin
            refill_r <= 1'b0;
            if (req_we_r) begin
                data_r[hit_way_s][idx_s] <= upd_block_s;
                if (WRITE_POLICY == 1) begin
                    dirty_r[idx_s][hit_way_s] <= 1'b1;
                end else begin
                    dirty_r[idx_s][hit_way_s] <= dirty_r[idx_s][hit_way_s];
                end
            end else begin
                data_r[hit_way_s][idx_s] <= data_r[hit_way_s][idx_s];
            end
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == hit_way_s) begin
                    age_r[idx_s][w] <= {WAY_W{1'b0}};
                end else if (age_r[idx_s][w] < age_r[idx_s][hit_way_s]) begin
                    age_r[idx_s][w] <= age_r[idx_s][w] + WAY_W'(1);
                end else begin
                    age_r[idx_s][w] <= age_r[idx_s][w];
                end
            end
        end else if ((state_r == ALLOCATE) && mem_ack) begin
            refill_r                  <= 1'b1;
            data_r[victim_r][idx_s]   <= mem_rdata;
            tag_r[victim_r][idx_s]    <= tag_s;
            valid_r[idx_s][victim_r]  <= 1'b1;
            dirty_r[idx_s][victim_r]  <= 1'b0;
        end else begin
            refill_r <= refill_r;
        end
    end

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl: a write-back instance and a write-through instance share
// the stimulus; use_wt selects which instance's outputs are checked.
module tb_cache_nway_ctrl;
    localparam logic [127:0] BLK_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] BLK_B = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] BLK_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] BLK_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    localparam logic [127:0] BLK_E = {32'hE3, 32'hE2, 32'hE1, 32'hE0};

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_valid, cpu_req_we, mem_ack;
    logic [31:0]  cpu_req_addr, cpu_req_wdata;
    logic [127:0] mem_rdata;
    logic         use_wt;

    logic         wb_ready, wb_resp_valid, wb_mem_req, wb_mem_we;
    logic [31:0]  wb_rdata, wb_mem_addr, wb_hit, wb_miss;
    logic [127:0] wb_mem_wdata;
    logic         wt_ready, wt_resp_valid, wt_mem_req, wt_mem_we;
    logic [31:0]  wt_rdata, wt_mem_addr, wt_hit, wt_miss;
    logic [127:0] wt_mem_wdata;

    logic         o_ready, o_resp_valid, o_mem_req, o_mem_we;
    logic [31:0]  o_rdata, o_mem_addr, o_hit, o_miss;
    logic [127:0] o_mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign o_ready      = use_wt ? wt_ready      : wb_ready;
    assign o_resp_valid = use_wt ? wt_resp_valid : wb_resp_valid;
    assign o_rdata      = use_wt ? wt_rdata      : wb_rdata;
    assign o_mem_req    = use_wt ? wt_mem_req    : wb_mem_req;
    assign o_mem_we     = use_wt ? wt_mem_we     : wb_mem_we;
    assign o_mem_addr   = use_wt ? wt_mem_addr   : wb_mem_addr;
    assign o_mem_wdata  = use_wt ? wt_mem_wdata  : wb_mem_wdata;
    assign o_hit        = use_wt ? wt_hit        : wb_hit;
    assign o_miss       = use_wt ? wt_miss       : wb_miss;

    cache_nway_ctrl #(.WRITE_POLICY(1)) dut_wb (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(wb_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(wb_resp_valid), .cpu_resp_rdata(wb_rdata),
        .mem_req(wb_mem_req), .mem_we(wb_mem_we), .mem_addr(wb_mem_addr), .mem_wdata(wb_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(wb_hit), .miss_count(wb_miss)
    );

    cache_nway_ctrl #(.WRITE_POLICY(0)) dut_wt (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(wt_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(wt_resp_valid), .cpu_resp_rdata(wt_rdata),
        .mem_req(wt_mem_req), .mem_we(wt_mem_we), .mem_addr(wt_mem_addr), .mem_wdata(wt_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(wt_hit), .miss_count(wt_miss)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_req_valid = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
    endtask

    task automatic mem_serve(input logic exp_we, input logic [31:0] exp_addr,
                             input logic [127:0] rblk, output logic [127:0] wblk);
        int n = 0;
        @(negedge clk);
        while (!o_mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mem_req", {31'd0, o_mem_req}, 32'd1);
        check("mem_we", {31'd0, o_mem_we}, {31'd0, exp_we});
        check("mem_addr", o_mem_addr, exp_addr);
        check("resp_during_mem", {31'd0, o_resp_valid}, 32'd0);
        wblk      = o_mem_wdata;
        mem_rdata = rblk;
        mem_ack   = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rdata);
        int n = 0;
        @(negedge clk);
        while (!o_resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("resp_valid", {31'd0, o_resp_valid}, 32'd1);
        rdata = o_rdata;
    endtask

    task automatic read_miss(input logic [31:0] addr, input logic [127:0] blk, input logic [31:0] exp);
        logic [127:0] wb;
        logic [31:0]  r;
        issue(1'b0, addr, 32'd0);
        mem_serve(1'b0, {addr[31:4], 4'd0}, blk, wb);
        wait_resp(r);
        check("miss_rdata", r, exp);
    endtask

    task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        issue(1'b0, addr, 32'd0);
        wait_resp(r);
        check("hit_rdata", r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  r;
        logic [127:0] wb;
        int           n;
        reset = 1'b1; use_wt = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = 32'd0; cpu_req_wdata = 32'd0;
        mem_rdata = 128'd0; mem_ack = 1'b0;
        #12;
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_resp", {31'd0, o_resp_valid}, 32'd0);
        check("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        check("rst_hit", o_hit, 32'd0);
        check("rst_miss", o_miss, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, o_ready}, 32'd1);

        // Cold miss, then a hit with two-edge latency
        read_miss(32'h40, BLK_A, 32'h11);
        check("cold_miss_count", o_miss, 32'd1);
        issue(1'b0, 32'h44, 32'd0);
        @(negedge clk);
        check("hit_not_early", {31'd0, o_resp_valid}, 32'd0);
        check("hit_no_mem", {31'd0, o_mem_req}, 32'd0);
        @(negedge clk);
        check("hit_resp", {31'd0, o_resp_valid}, 32'd1);
        check("hit_word1", o_rdata, 32'h22);
        check("hit_count1", o_hit, 32'd1);

        // Fill set 0, dirty 0x000, make it LRU and evict it
        read_miss(32'h000, BLK_B, 32'hA0);
        read_miss(32'h080, BLK_C, 32'hC0);
        read_miss(32'h0C0, BLK_D, 32'hD0);
        issue(1'b1, 32'h000, 32'hDEADBEEF);
        wait_resp(r);
        check("write_rdata_zero", r, 32'd0);
        read_hit(32'h040, 32'h11);
        read_hit(32'h080, 32'hC0);
        read_hit(32'h0C0, 32'hD0);
        issue(1'b0, 32'h100, 32'd0);
        mem_serve(1'b1, 32'h000, BLK_E, wb);
        check_blk("writeback_block", wb, {32'hA3, 32'hA2, 32'hA1, 32'hDEADBEEF});
        mem_serve(1'b0, 32'h100, BLK_E, wb);
        wait_resp(r);
        check("evict_rdata", r, 32'hE0);
        check("wb_miss_count", o_miss, 32'd5);
        check("wb_hit_count", o_hit, 32'd5);

        // Same pattern without the write: clean victim, no write-back
        do_reset();
        read_miss(32'h040, BLK_A, 32'h11);
        read_miss(32'h000, BLK_B, 32'hA0);
        read_miss(32'h080, BLK_C, 32'hC0);
        read_miss(32'h0C0, BLK_D, 32'hD0);
        read_hit(32'h040, 32'h11);
        read_hit(32'h080, 32'hC0);
        read_hit(32'h0C0, 32'hD0);
        read_miss(32'h100, BLK_E, 32'hE0);
        read_hit(32'h040, 32'h11);
        read_miss(32'h000, BLK_B, 32'hA0);
        check("clean_miss_count", o_miss, 32'd6);
        check("clean_hit_count", o_hit, 32'd4);

        // Reset while ALLOCATE holds mem_req
        issue(1'b0, 32'h200, 32'd0);
        n = 0;
        @(negedge clk);
        while (!o_mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("alloc_req", {31'd0, o_mem_req}, 32'd1);
        check("alloc_addr", o_mem_addr, 32'h200);
        reset = 1'b1;
        #1;
        check("async_rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", {31'd0, o_ready}, 32'd1);
        check("midrst_miss_zero", o_miss, 32'd0);
        read_miss(32'h40, BLK_A, 32'h11);
        check("midrst_remiss", o_miss, 32'd1);

        // Held request: ready low through the miss, re-accepted right after the pulse
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h80;
        @(posedge clk);
        #1;
        check("held_ready_low", {31'd0, o_ready}, 32'd0);
        mem_serve(1'b0, 32'h80, BLK_C, wb);
        check("held_ready_after_ack", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        check("held_no_resp_yet", {31'd0, o_resp_valid}, 32'd0);
        @(negedge clk);
        check("held_resp1", {31'd0, o_resp_valid}, 32'd1);
        check("held_ready_with_pulse", {31'd0, o_ready}, 32'd1);
        check("held_rdata1", o_rdata, 32'hC0);
        @(negedge clk);
        check("held_reaccepted", {31'd0, o_ready}, 32'd0);
        check("held_resp_gap", {31'd0, o_resp_valid}, 32'd0);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        check("held_resp2", {31'd0, o_resp_valid}, 32'd1);
        check("held_rdata2", o_rdata, 32'hC0);
        check("held_hit_count", o_hit, 32'd1);

        // Write-through instance
        use_wt = 1'b1;
        do_reset();
        read_miss(32'h40, BLK_A, 32'h11);
        issue(1'b1, 32'h44, 32'h5555);
        mem_serve(1'b1, 32'h40, BLK_A, wb);
        check_blk("wthru_block", wb, {32'h44, 32'h33, 32'h5555, 32'h11});
        wait_resp(r);
        check("wthru_rdata_zero", r, 32'd0);
        check("wthru_hit_count", o_hit, 32'd1);
        read_miss(32'h000, BLK_B, 32'hA0);
        read_miss(32'h080, BLK_C, 32'hC0);
        read_miss(32'h0C0, BLK_D, 32'hD0);
        issue(1'b0, 32'h100, 32'd0);
        mem_serve(1'b0, 32'h100, BLK_E, wb);
        wait_resp(r);
        check("wthru_evict_rdata", r, 32'hE0);
        check("wthru_miss_count", o_miss, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
